neighbor_output_processor: RTL

//  Transmit side of the PPU halo exchange; counterpart of the neighbor input path.

---
 rtl/ppu_pkg.sv | 19 +
 rtl/neighbor_output_processor_halo_scanner.sv | 76 +++++++
 rtl/neighbor_output_processor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU halo-exchange definitions: neighbor directions, transmit FSM states
// and the kernel-size to halo-width mapping.
package ppu_pkg;

   localparam int NEIGHBORS = 8;

   typedef enum logic [2:0] {
      DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
   } neighbor_dir_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_READ, ST_SEND, ST_DONE
   } tx_state_e;

   function automatic logic [2:0] halo_width(input logic [2:0] kernel_size);
      return kernel_size >> 1;
   endfunction

endpackage

// File: rtl/neighbor_output_processor_halo_scanner.sv
// Halo-band walker: holds the current (row,col), steps to the next halo position in
// raster order (skipping the interior) and reports which neighbors need the element.
module halo_scanner
   import ppu_pkg::*;
#(
   parameter int TILE_DIM = 16,
   parameter int CW       = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           h_i,
   input  logic                 advance_i,
   output logic [CW-1:0]        row_o,
   output logic [CW-1:0]        col_o,
   output logic                 last_o,
   output logic [NEIGHBORS-1:0] dest_o
);

   logic [CW-1:0] row_q, row_d, col_q, col_d;
   logic [CW-1:0] h_w, far_w, edge_w;
   logic          north, south, west, east;

   assign h_w    = CW'(h_i);
   assign far_w  = CW'(TILE_DIM) - h_w;
   assign edge_w = CW'(TILE_DIM - 1);

   assign north  = row_q < h_w;
   assign south  = row_q >= far_w;
   assign west   = col_q < h_w;
   assign east   = col_q >= far_w;
   assign last_o = (row_q == edge_w) && (col_q == edge_w);
   assign row_o  = row_q;
   assign col_o  = col_q;

   always_comb begin
      dest_o         = '0;
      dest_o[DIR_N]  = north;
      dest_o[DIR_NE] = north & east;
      dest_o[DIR_E]  = east;
      dest_o[DIR_SE] = south & east;
      dest_o[DIR_S]  = south;
      dest_o[DIR_SW] = south & west;
      dest_o[DIR_W]  = west;
      dest_o[DIR_NW] = north & west;
   end

   // NOTE: next-state defaults are assigned first so no path through the block infers a latch.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (advance_i) begin
         if (last_o) begin
            row_d = '0;
            col_d = '0;
         end else if (col_q == edge_w) begin
            row_d = row_q + 1'b1;
            col_d = '0;
         end else if (!north && !south && (col_q == h_w - 1'b1)) begin
            col_d = far_w;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/neighbor_output_processor.sv
// Transmit side of the PPU halo exchange: walks the halo band of the output tile, reads
// each element and writes non-zero values to every neighbor whose halo contains them.
module neighbor_output_processor
   import ppu_pkg::*;
#(
   parameter int BANK_COUNT = 32,
   parameter int TILE_SIZE  = 256,
   parameter int TILE_DIM   = 16,
   localparam int CW        = $clog2(TILE_SIZE),
   localparam int BW        = $clog2(BANK_COUNT)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           kernel_size,
   input  logic                 channel_group_done,
   output logic [BW-1:0]        buffer_bank_read,
   output logic [CW-1:0]        buffer_bank_entry,
   input  logic [7:0]           buffer_data_read,
   input  logic [NEIGHBORS-1:0] neighbor_cts,
   input  logic [NEIGHBORS-1:0] neighbor_exchange_done,
   output logic [7:0]           neighbor_output_value [NEIGHBORS],
   output logic [CW-1:0]        neighbor_output_row [NEIGHBORS],
   output logic [CW-1:0]        neighbor_output_column [NEIGHBORS],
   output logic [NEIGHBORS-1:0] neighbor_output_write_enable,
   output logic                 exchange_done,
   output logic                 cycle_done
);

   localparam logic [2*CW-1:0] DIM_W   = (2*CW)'(TILE_DIM);
   localparam logic [2*CW-1:0] BANKS_W = (2*CW)'(BANK_COUNT);

   tx_state_e            state_q;
   logic [2:0]           h_q;
   logic                 exchange_done_q, cycle_done_q;
   logic [CW-1:0]        row, col;
   logic                 last;
   logic [NEIGHBORS-1:0] dest, strobe;
   logic                 data_nz, cts_ok, step;
   logic [2*CW-1:0]      lin;

   halo_scanner #(
      .TILE_DIM (TILE_DIM),
      .CW       (CW)
   ) u_scanner (
      .clk       (clk),
      .reset_n   (reset_n),
      .h_i       (h_q),
      .advance_i (step),
      .row_o     (row),
      .col_o     (col),
      .last_o    (last),
      .dest_o    (dest)
   );

   // The address follows the scanner registers, so it stays put while a send stalls.
   assign lin               = {{CW{1'b0}}, row} * DIM_W + {{CW{1'b0}}, col};
   assign buffer_bank_read  = BW'(lin % BANKS_W);
   assign buffer_bank_entry = CW'(lin / BANKS_W);

   assign data_nz = |buffer_data_read;
   assign cts_ok  = (neighbor_cts & dest) == dest;
   assign step    = (state_q == ST_SEND) && (!data_nz || cts_ok);
   assign strobe  = ((state_q == ST_SEND) && data_nz && cts_ok) ? dest : '0;

   // Strobes must coincide with the cycle CTS is seen high, so the lanes are combinational.
   always_comb begin
      for (int i = 0; i < NEIGHBORS; i++) begin
         neighbor_output_value[i]  = strobe[i] ? buffer_data_read : '0;
         neighbor_output_row[i]    = strobe[i] ? row : '0;
         neighbor_output_column[i] = strobe[i] ? col : '0;
      end
   end

   assign neighbor_output_write_enable = strobe;
   assign exchange_done                = exchange_done_q;
   assign cycle_done                   = cycle_done_q;

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         h_q             <= '0;
         exchange_done_q <= 1'b0;
         cycle_done_q    <= 1'b0;
      end else begin
         cycle_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (channel_group_done) begin
                  h_q <= halo_width(kernel_size);
                  if (halo_width(kernel_size) == 3'd0) begin
                     state_q         <= ST_DONE;
                     exchange_done_q <= 1'b1;
                  end else begin
                     state_q <= ST_READ;
                  end
               end
            end
            ST_READ: state_q <= ST_SEND;
            ST_SEND: begin
               if (step && last) begin
                  state_q         <= ST_DONE;
                  exchange_done_q <= 1'b1;
               end else if (step) begin
                  state_q <= ST_READ;
               end
            end
            ST_DONE: begin
               if (&neighbor_exchange_done) begin
                  cycle_done_q    <= 1'b1;
                  exchange_done_q <= 1'b0;
                  state_q         <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
